fetch_pc_ras_reg: RTL and testbench

- Next-generation fetch-stage predicted-PC register for the Y86-64 pipeline.
- Latches the next fetch PC each cycle with a defined priority order:
  1. Write-back and memory-stage redirects.
  2. Fetch stall.
  3. Return-address-stack (RAS) prediction for `ret`.
  4. Default predicted PC from fetch logic.
- Replaces bubble-stalling on `ret` with a parametrised-depth circular RAS.
- Sits between fetch PC-select logic and instruction memory address.

---
 rtl/fetch_pc_ras_reg.sv | 96 +++++++++
 tb/tb_fetch_pc_ras_reg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_ras_reg.sv
// Fetch-stage predicted-PC register with a circular return-address stack.
// Redirects win over stall, stall over RAS-predicted ret, which wins over the default PC.
module fetch_pc_ras_reg #(
    parameter int unsigned          ADDR_W    = 64,
    parameter int unsigned          RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           F_stall,
    input  logic                           f_valid,
    input  logic [3:0]                     f_icode,
    input  logic [ADDR_W-1:0]              f_valP,
    input  logic [ADDR_W-1:0]              f_predPC,
    input  logic                           M_redirect,
    input  logic [ADDR_W-1:0]              M_target,
    input  logic                           W_redirect,
    input  logic [ADDR_W-1:0]              W_target,
    output logic [ADDR_W-1:0]              F_predPC,
    output logic                           ras_hit,
    output logic                           ras_miss,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_overflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top_q;
    logic [PTR_W-1:0]  top_inc;
    logic [PTR_W-1:0]  top_dec;
    logic              fetch_open;
    logic              is_call;
    logic              is_ret;
    logic              ras_empty;
    logic              ras_full;
    logic              push_en;

    assign top_inc    = top_q + PTR_W'(1);
    assign top_dec    = top_q - PTR_W'(1);
    assign fetch_open = !W_redirect && !M_redirect && !F_stall;
    assign is_call    = f_valid && (f_icode == 4'h8);
    assign is_ret     = f_valid && (f_icode == 4'h9);
    assign ras_empty  = (ras_count == '0);
    assign ras_full   = (ras_count == CNT_W'(RAS_DEPTH));
    assign push_en    = !rst && fetch_open && is_call;

    // Entries are never reset; ras_count alone decides which ones are live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            ras_mem[top_inc] <= f_valP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            F_predPC     <= RESET_PC;
            ras_hit      <= 1'b0;
            ras_miss     <= 1'b0;
            ras_count    <= '0;
            ras_overflow <= 1'b0;
            top_q        <= '0;
        end else begin
            ras_hit  <= 1'b0;
            ras_miss <= 1'b0;
            if (W_redirect) begin
                F_predPC <= W_target;
            end else if (M_redirect) begin
                F_predPC <= M_target;
            end else if (F_stall) begin
                F_predPC <= F_predPC;
            end else if (is_ret && !ras_empty) begin
                F_predPC  <= ras_mem[top_q];
                top_q     <= top_dec;
                ras_count <= ras_count - CNT_W'(1);
                ras_hit   <= 1'b1;
            end else if (is_ret) begin
                F_predPC <= f_predPC;
                ras_miss <= 1'b1;
            end else if (is_call) begin
                F_predPC <= f_predPC;
                top_q    <= top_inc;
                // A full stack keeps its count; the push lands on the oldest entry.
                if (ras_full) begin
                    ras_overflow <= 1'b1;
                end else begin
                    ras_count <= ras_count + CNT_W'(1);
                end
            end else begin
                F_predPC <= f_predPC;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_ras_reg.sv
// Bench for fetch_pc_ras_reg: directed scenarios then random traffic, checked
// against a queue-based model of the predicted PC and return-address stack.
module tb_fetch_pc_ras_reg;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        F_stall;
    logic        f_valid;
    logic [3:0]  f_icode;
    logic [63:0] f_valP;
    logic [63:0] f_predPC;
    logic        M_redirect;
    logic [63:0] M_target;
    logic        W_redirect;
    logic [63:0] W_target;
    logic [63:0] F_predPC;
    logic        ras_hit;
    logic        ras_miss;
    logic [3:0]  ras_count;
    logic        ras_overflow;

    fetch_pc_ras_reg #(.ADDR_W(64), .RAS_DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst(rst), .F_stall(F_stall), .f_valid(f_valid),
        .f_icode(f_icode), .f_valP(f_valP), .f_predPC(f_predPC),
        .M_redirect(M_redirect), .M_target(M_target),
        .W_redirect(W_redirect), .W_target(W_target),
        .F_predPC(F_predPC), .ras_hit(ras_hit), .ras_miss(ras_miss),
        .ras_count(ras_count), .ras_overflow(ras_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors;
    int miscompares;

    logic [63:0] m_pc;
    logic        m_hit;
    logic        m_miss;
    logic        m_ovf;
    logic [63:0] m_ras [$];

    // Reference: the stack is a queue of return addresses, newest at the back,
    // capped at DEPTH by discarding the oldest.
    task automatic model_step();
        if (rst) begin
            m_pc = 64'h0; m_hit = 0; m_miss = 0; m_ovf = 0;
            m_ras.delete();
        end else begin
            m_hit = 0; m_miss = 0;
            if (W_redirect)      m_pc = W_target;
            else if (M_redirect) m_pc = M_target;
            else if (F_stall)    m_pc = m_pc;
            else if (f_valid && f_icode == 4'd9) begin
                if (m_ras.size() > 0) begin
                    m_pc = m_ras.pop_back();
                    m_hit = 1;
                end else begin
                    m_pc = f_predPC;
                    m_miss = 1;
                end
            end else if (f_valid && f_icode == 4'd8) begin
                m_pc = f_predPC;
                m_ras.push_back(f_valP);
                if (m_ras.size() > DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1;
                end
            end else begin
                m_pc = f_predPC;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk({tag, " F_predPC"},     F_predPC,     m_pc);
        chk({tag, " ras_hit"},      64'(ras_hit),      64'(m_hit));
        chk({tag, " ras_miss"},     64'(ras_miss),     64'(m_miss));
        chk({tag, " ras_count"},    64'(ras_count),    64'(m_ras.size()));
        chk({tag, " ras_overflow"}, 64'(ras_overflow), 64'(m_ovf));
    endtask

    task automatic drive(input logic r, input logic w, input logic [63:0] wt,
                         input logic m, input logic [63:0] mt, input logic st,
                         input logic v, input logic [3:0] ic,
                         input logic [63:0] vp, input logic [63:0] pp);
        rst = r; W_redirect = w; W_target = wt; M_redirect = m; M_target = mt;
        F_stall = st; f_valid = v; f_icode = ic; f_valP = vp; f_predPC = pp;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        m_pc = 64'h0; m_hit = 0; m_miss = 0; m_ovf = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 64'h40);
        #1;

        // Reset held two cycles, then release
        step("reset0");
        step("reset1");
        drive(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 64'h40);
        step("release");
        chk("release pc literal", F_predPC, 64'h40);

        // Call/ret pair
        drive(0, 0, 0, 0, 0, 0, 1, 4'h8, 64'h1A, 64'h100);
        step("call");
        chk("call pc literal", F_predPC, 64'h100);
        drive(0, 0, 0, 0, 0, 0, 1, 4'h9, 0, 64'h102);
        step("ret");
        chk("ret pc literal", F_predPC, 64'h1A);
        chk("ret hit literal", 64'(ras_hit), 64'h1);

        // Stall beats a ret with two live entries
        drive(0, 0, 0, 0, 0, 0, 1, 4'h8, 64'hA0, 64'h300);
        step("call_a");
        drive(0, 0, 0, 0, 0, 0, 1, 4'h8, 64'hB0, 64'h400);
        step("call_b");
        drive(0, 0, 0, 0, 0, 1, 1, 4'h9, 0, 64'h999);
        step("stall_ret");
        chk("stall count literal", 64'(ras_count), 64'd2);

        // W redirect beats M redirect and stall
        drive(0, 1, 64'h200, 1, 64'h300, 1, 1, 4'h9, 0, 64'h999);
        step("redirect");
        chk("redirect pc literal", F_predPC, 64'h200);
        drive(0, 0, 0, 1, 64'h300, 1, 1, 4'h8, 64'h7, 64'h999);
        step("m_redirect");

        // Overflow and wrap from a clean stack
        drive(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
        step("reset_ovf");
        for (int i = 1; i <= 9; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 4'h8, 64'(i * 16), 64'h1000 + 64'(i));
            step("ovf_call");
        end
        chk("ovf count literal", 64'(ras_count), 64'd8);
        chk("ovf flag literal", 64'(ras_overflow), 64'd1);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 4'h9, 0, 64'h2000);
            step("ovf_ret");
            chk("ovf ret literal", F_predPC, 64'(16 * (9 - i)));
        end
        drive(0, 0, 0, 0, 0, 0, 1, 4'h9, 0, 64'h2222);
        step("ovf_ret9");
        chk("ret9 miss literal", 64'(ras_miss), 64'd1);

        // Underflow straight out of reset
        drive(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
        step("reset_uf");
        drive(0, 0, 0, 0, 0, 0, 1, 4'h9, 0, 64'h55);
        step("underflow");
        chk("underflow pc literal", F_predPC, 64'h55);
        drive(0, 0, 0, 0, 0, 0, 0, 4'h9, 0, 64'h60);
        step("after_underflow");

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [3:0] ic;
            r = int'($urandom_range(0, 9));
            ic = (r < 4) ? 4'h8 : (r < 8) ? 4'h9 : 4'($urandom_range(0, 7));
            drive($urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 5, {$urandom, $urandom},
                  $urandom_range(0, 99) < 5, {$urandom, $urandom},
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 85, ic,
                  {$urandom, $urandom}, {$urandom, $urandom});
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
